// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

    // Sequencer states: ecall path (E_*), mret path (M_*), then the redirect hand-off.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_E_MEPC  = 4'd1,
        ST_E_CAUSE = 4'd2,
        ST_E_ST_RD = 4'd3,
        ST_E_ST_WR = 4'd4,
        ST_E_TVEC  = 4'd5,
        ST_M_ST_RD = 4'd6,
        ST_M_ST_WR = 4'd7,
        ST_M_EPC   = 4'd8,
        ST_REDIR   = 4'd9
    } trap_state_t;

    // Machine-mode CSR addresses touched by the sequencer.
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // mstatus field positions.
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_mstatus_upd.sv
// Combinational mstatus rewrite for trap entry (ecall) and trap return (mret).
module trap_mstatus_upd
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_st,
    input  logic            i_is_mret,
    output logic [XLEN-1:0] o_st
);

    // Entry stacks MIE into MPIE and masks interrupts; return restores MIE and re-arms MPIE.
    // Only M-mode exists, so MPP is always forced to 2'b11.
    always_comb begin
        o_st = i_st;
        if (i_is_mret) begin
            o_st[MSTATUS_MIE]  = i_st[MSTATUS_MPIE];
            o_st[MSTATUS_MPIE] = 1'b1;
        end else begin
            o_st[MSTATUS_MPIE] = i_st[MSTATUS_MIE];
            o_st[MSTATUS_MIE]  = 1'b0;
        end
        o_st[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer in front of the machine-mode CSR file. Takes ecall/mret from the
// EXU, performs the CSR updates one per cycle, and hands the new PC to the IFU.
// While idle the single CSR port belongs to the EXU's Zicsr traffic.
//
// Handshakes (both valid/ready): a transfer happens on a rising edge where valid and
// ready are both high. The sender holds valid and its payload stable until that edge;
// ready may be asserted independently of valid. in_* is accepted only in IDLE;
// redirect_valid/redirect_pc stay asserted and stable in REDIR until redirect_ready.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ECALL_CAUSE = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_ecall,
    input  logic            in_mret,
    input  logic [11:0]     exu_csr_addr,
    input  logic [XLEN-1:0] exu_csr_wdata,
    input  logic            exu_csr_wen,
    input  logic            exu_csr_ren,
    output logic [XLEN-1:0] exu_csr_rdata,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] w_csr_data,
    output logic            w_csr_en,
    output logic            r_csr_en,
    input  logic [XLEN-1:0] r_csr_data,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic [3:0]      dbg_state
);

    trap_state_t     r_state;
    logic [XLEN-1:0] r_pc_q;
    logic [XLEN-1:0] r_st_q;
    logic [XLEN-1:0] r_tgt_q;
    logic            r_in_ready;
    logic            r_redirect_valid;
    logic            r_busy;

    logic            w_accept;
    logic            w_is_idle;
    logic            w_st_is_mret;
    logic [XLEN-1:0] w_st_new;
    logic [11:0]     w_fsm_addr;
    logic [XLEN-1:0] w_fsm_wdata;
    logic            w_fsm_wen;
    logic            w_fsm_ren;

    assign w_is_idle    = (r_state == ST_IDLE);
    assign w_accept     = in_valid & r_in_ready;
    assign w_st_is_mret = (r_state == ST_M_ST_WR);

    assign in_ready       = r_in_ready;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_tgt_q;
    assign busy           = r_busy;
    assign dbg_state      = r_state;

    // The new mstatus is derived from the latched copy, so the write cycle never depends
    // on r_csr_data combinationally.
    trap_mstatus_upd #(
        .XLEN (XLEN)
    ) u_mstatus_upd (
        .i_st      (r_st_q),
        .i_is_mret (w_st_is_mret),
        .o_st      (w_st_new)
    );

    // Sequencer: state, latched operands and the registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_pc_q           <= '0;
            r_st_q           <= '0;
            r_tgt_q          <= '0;
            r_in_ready       <= 1'b1;
            r_redirect_valid <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pc_q <= in_pc;
                        // ecall wins when both flags are set; anything else is simply consumed.
                        if (in_ecall) begin
                            r_state    <= ST_E_MEPC;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end else if (in_mret) begin
                            r_state    <= ST_M_ST_RD;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                ST_E_MEPC:  r_state <= ST_E_CAUSE;
                ST_E_CAUSE: r_state <= ST_E_ST_RD;
                ST_E_ST_RD: begin
                    r_st_q  <= r_csr_data;
                    r_state <= ST_E_ST_WR;
                end
                ST_E_ST_WR: r_state <= ST_E_TVEC;
                ST_E_TVEC: begin
                    // Direct mode only: the low mode bits of mtvec are dropped.
                    r_tgt_q          <= r_csr_data & ~XLEN'(3);
                    r_redirect_valid <= 1'b1;
                    r_state          <= ST_REDIR;
                end
                ST_M_ST_RD: begin
                    r_st_q  <= r_csr_data;
                    r_state <= ST_M_ST_WR;
                end
                ST_M_ST_WR: r_state <= ST_M_EPC;
                ST_M_EPC: begin
                    r_tgt_q          <= r_csr_data;
                    r_redirect_valid <= 1'b1;
                    r_state          <= ST_REDIR;
                end
                ST_REDIR: begin
                    // Going back to IDLE here means the earliest new accept is the next cycle.
                    if (redirect_ready) begin
                        r_redirect_valid <= 1'b0;
                        r_in_ready       <= 1'b1;
                        r_busy           <= 1'b0;
                        r_state          <= ST_IDLE;
                    end
                end
                default: begin
                    r_redirect_valid <= 1'b0;
                    r_in_ready       <= 1'b1;
                    r_busy           <= 1'b0;
                    r_state          <= ST_IDLE;
                end
            endcase
        end
    end

    // CSR operation the sequencer issues in its current state (one access per cycle).
    always_comb begin
        w_fsm_addr  = '0;
        w_fsm_wdata = '0;
        w_fsm_wen   = 1'b0;
        w_fsm_ren   = 1'b0;
        case (r_state)
            ST_E_MEPC: begin
                w_fsm_addr  = CSR_MEPC;
                w_fsm_wdata = r_pc_q;
                w_fsm_wen   = 1'b1;
            end
            ST_E_CAUSE: begin
                w_fsm_addr  = CSR_MCAUSE;
                w_fsm_wdata = XLEN'(ECALL_CAUSE);
                w_fsm_wen   = 1'b1;
            end
            ST_E_ST_RD, ST_M_ST_RD: begin
                w_fsm_addr = CSR_MSTATUS;
                w_fsm_ren  = 1'b1;
            end
            ST_E_ST_WR, ST_M_ST_WR: begin
                w_fsm_addr  = CSR_MSTATUS;
                w_fsm_wdata = w_st_new;
                w_fsm_wen   = 1'b1;
            end
            ST_E_TVEC: begin
                w_fsm_addr = CSR_MTVEC;
                w_fsm_ren  = 1'b1;
            end
            ST_M_EPC: begin
                w_fsm_addr = CSR_MEPC;
                w_fsm_ren  = 1'b1;
            end
            default: ;
        endcase
    end

    // CSR port ownership: EXU when idle, sequencer otherwise (EXU writes dropped, reads return 0).
    always_comb begin
        if (w_is_idle) begin
            csr_addr      = exu_csr_addr;
            w_csr_data    = exu_csr_wdata;
            w_csr_en      = exu_csr_wen;
            r_csr_en      = exu_csr_ren;
            exu_csr_rdata = r_csr_data;
        end else begin
            csr_addr      = w_fsm_addr;
            w_csr_data    = w_fsm_wdata;
            w_csr_en      = w_fsm_wen;
            r_csr_en      = w_fsm_ren;
            exu_csr_rdata = '0;
        end
    end

    // The EXU must not touch the CSR port while a trap sequence is running.
    a_exu_quiet_when_busy: assert property (
        @(posedge clk) disable iff (rst)
        (r_state != ST_IDLE) |-> !(exu_csr_wen || exu_csr_ren)
    );

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a behavioural CSR file (combinational read,
// negedge commit) and an expected-redirect queue.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic        in_ecall = 1'b0;
    logic        in_mret = 1'b0;
    logic [11:0] exu_csr_addr = '0;
    logic [31:0] exu_csr_wdata = '0;
    logic        exu_csr_wen = 1'b0;
    logic        exu_csr_ren = 1'b0;
    logic [31:0] exu_csr_rdata;
    logic [11:0] csr_addr;
    logic [31:0] w_csr_data;
    logic        w_csr_en;
    logic        r_csr_en;
    logic [31:0] r_csr_data;
    logic        redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [3:0]  dbg_state;

    int n_tot = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    trap_ctrl #(
        .XLEN        (32),
        .ECALL_CAUSE (11)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_ecall       (in_ecall),
        .in_mret        (in_mret),
        .exu_csr_addr   (exu_csr_addr),
        .exu_csr_wdata  (exu_csr_wdata),
        .exu_csr_wen    (exu_csr_wen),
        .exu_csr_ren    (exu_csr_ren),
        .exu_csr_rdata  (exu_csr_rdata),
        .csr_addr       (csr_addr),
        .w_csr_data     (w_csr_data),
        .w_csr_en       (w_csr_en),
        .r_csr_en       (r_csr_en),
        .r_csr_data     (r_csr_data),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    // CSR file model
    logic [31:0] csr_mem [0:4095];
    assign r_csr_data = csr_mem[csr_addr];
    always @(negedge clk) begin
        if (w_csr_en) csr_mem[csr_addr] <= w_csr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 1'b0; in_ecall = 1'b0; in_mret = 1'b0; in_pc = '0;
        exu_csr_addr = '0; exu_csr_wdata = '0; exu_csr_wen = 1'b0; exu_csr_ren = 1'b0;
    endtask

    task automatic exu_write(input logic [11:0] a, input logic [31:0] d);
        cyc();
        exu_csr_addr = a; exu_csr_wdata = d; exu_csr_wen = 1'b1;
        cyc();
        clear_in();
    endtask

    // scoreboard: every redirect handshake must match the next expected target
    always @(negedge clk) begin
        if (!rst && redirect_valid && redirect_ready) begin
            if (exp_q.size() == 0) begin
                n_tot++;
                n_bad++;
                $display("FAIL redir_unexpected actual=%h expected=none", redirect_pc);
            end else begin
                chk("redir_pc", redirect_pc, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic        v;
        logic        ec;
        logic        mr;
        logic [31:0] pc;
        logic [11:0] a;
        logic [31:0] wd;
        logic        we;
        logic        re;
        logic        e_rdy;
        logic        e_busy;
        logic [11:0] e_addr;
        logic [31:0] e_wd;
        logic        e_we;
        logic        e_re;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        for (int i = 0; i < 4096; i++) csr_mem[i] = '0;

        // idle pass-through and non-trap consumption vectors
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,   12'h305, 32'h1234,      1'b1, 1'b0,
                    1'b1, 1'b0, 12'h305, 32'h1234,      1'b1, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0,   12'h305, 32'h0,         1'b0, 1'b1,
                    1'b1, 1'b0, 12'h305, 32'h0,         1'b0, 1'b1, 32'h1234};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0,   12'h300, 32'h8,         1'b1, 1'b0,
                    1'b1, 1'b0, 12'h300, 32'h8,         1'b1, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0,   12'h300, 32'h0,         1'b0, 1'b1,
                    1'b1, 1'b0, 12'h300, 32'h0,         1'b0, 1'b1, 32'h8};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0,   12'h305, 32'h8000_0103, 1'b1, 1'b0,
                    1'b1, 1'b0, 12'h305, 32'h8000_0103, 1'b1, 1'b0, 32'h1234};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0,   12'h305, 32'h0,         1'b0, 1'b1,
                    1'b1, 1'b0, 12'h305, 32'h0,         1'b0, 1'b1, 32'h8000_0103};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h100, 12'h000, 32'h0,         1'b0, 1'b0,
                    1'b1, 1'b0, 12'h000, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0,   12'h000, 32'h0,         1'b0, 1'b0,
                    1'b1, 1'b0, 12'h000, 32'h0,         1'b0, 1'b0, 32'h0};

        // reset state
        cyc();
        cyc();
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_redir_valid", redirect_valid, 1'b0);
        chk("rst_redir_pc", redirect_pc, 32'h0);
        chk("rst_wen", w_csr_en, 1'b0);
        chk("rst_ren", r_csr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // table-driven idle vectors
        for (int i = 0; i < 8; i++) begin
            cyc();
            in_valid = vecs[i].v; in_ecall = vecs[i].ec; in_mret = vecs[i].mr; in_pc = vecs[i].pc;
            exu_csr_addr = vecs[i].a; exu_csr_wdata = vecs[i].wd;
            exu_csr_wen = vecs[i].we; exu_csr_ren = vecs[i].re;
            #1;
            chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_addr", i), csr_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_wdata", i), w_csr_data, vecs[i].e_wd);
            chk($sformatf("v%0d_wen", i), w_csr_en, vecs[i].e_we);
            chk($sformatf("v%0d_ren", i), r_csr_en, vecs[i].e_re);
            chk($sformatf("v%0d_exu_rdata", i), exu_csr_rdata, vecs[i].e_rd);
            chk($sformatf("v%0d_redir_valid", i), redirect_valid, 1'b0);
        end
        cyc();
        clear_in();

        // ecall: pc=0x8000_0010, mstatus=0x8, mtvec=0x8000_0103
        cyc();
        in_valid = 1'b1; in_ecall = 1'b1; in_pc = 32'h8000_0010;
        #1 chk("ec_accept_rdy", in_ready, 1'b1);
        exp_q.push_back(32'h8000_0100);
        cyc(); clear_in(); #1;
        chk("ec1_wen", w_csr_en, 1'b1);
        chk("ec1_addr", csr_addr, 12'h341);
        chk("ec1_wdata", w_csr_data, 32'h8000_0010);
        chk("ec1_busy", busy, 1'b1);
        chk("ec1_in_ready", in_ready, 1'b0);
        cyc(); #1;
        chk("ec2_addr", csr_addr, 12'h342);
        chk("ec2_wdata", w_csr_data, 32'd11);
        cyc(); #1;
        chk("ec3_ren", r_csr_en, 1'b1);
        chk("ec3_addr", csr_addr, 12'h300);
        chk("ec3_exu_rdata", exu_csr_rdata, 32'h0);
        cyc(); #1;
        chk("ec4_wen", w_csr_en, 1'b1);
        chk("ec4_wdata", w_csr_data, 32'h0000_1880);
        cyc(); #1;
        chk("ec5_addr", csr_addr, 12'h305);
        chk("ec5_redir_valid", redirect_valid, 1'b0);
        cyc();
        redirect_ready = 1'b1;
        #1;
        chk("ec6_redir_valid", redirect_valid, 1'b1);
        chk("ec6_redir_pc", redirect_pc, 32'h8000_0100);
        chk("ec6_wen", w_csr_en, 1'b0);
        cyc();
        redirect_ready = 1'b0;
        #1;
        chk("ec_done_busy", busy, 1'b0);
        chk("ec_done_in_ready", in_ready, 1'b1);
        chk("ec_mepc", csr_mem[12'h341], 32'h8000_0010);
        chk("ec_mcause", csr_mem[12'h342], 32'd11);
        chk("ec_mstatus", csr_mem[12'h300], 32'h0000_1880);

        // mret: mepc=0x8000_0014, mstatus=0x1880
        exu_write(12'h341, 32'h8000_0014);
        in_valid = 1'b1; in_mret = 1'b1; in_pc = 32'h8000_0050;
        #1 chk("mr_accept_rdy", in_ready, 1'b1);
        exp_q.push_back(32'h8000_0014);
        cyc(); clear_in(); #1;
        chk("mr1_ren", r_csr_en, 1'b1);
        chk("mr1_addr", csr_addr, 12'h300);
        cyc(); #1;
        chk("mr2_wen", w_csr_en, 1'b1);
        chk("mr2_wdata", w_csr_data, 32'h0000_1888);
        cyc(); #1;
        chk("mr3_addr", csr_addr, 12'h341);
        chk("mr3_redir_valid", redirect_valid, 1'b0);
        cyc();
        redirect_ready = 1'b1;
        #1;
        chk("mr4_redir_valid", redirect_valid, 1'b1);
        chk("mr4_redir_pc", redirect_pc, 32'h8000_0014);
        cyc();
        redirect_ready = 1'b0;
        #1;
        chk("mr_done_busy", busy, 1'b0);
        chk("mr_mstatus", csr_mem[12'h300], 32'h0000_1888);

        // redirect back-pressure with an instruction offered the whole time
        cyc();
        in_valid = 1'b1; in_mret = 1'b1; in_pc = 32'h8000_0060;
        exp_q.push_back(32'h8000_0014);
        cyc(); clear_in();
        cyc();
        cyc();
        cyc();
        in_valid = 1'b1; in_ecall = 1'b1; in_pc = 32'h0000_0999;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk($sformatf("st%0d_redir_valid", j), redirect_valid, 1'b1);
            chk($sformatf("st%0d_redir_pc", j), redirect_pc, 32'h8000_0014);
            chk($sformatf("st%0d_in_ready", j), in_ready, 1'b0);
            cyc();
        end
        redirect_ready = 1'b1;
        #1;
        chk("st_hs_redir_valid", redirect_valid, 1'b1);
        chk("st_hs_in_ready", in_ready, 1'b0);
        cyc();
        redirect_ready = 1'b0;
        clear_in();
        #1;
        chk("st_after_busy", busy, 1'b0);
        chk("st_after_in_ready", in_ready, 1'b1);
        chk("st_after_state", dbg_state, 4'd0);
        chk("st_after_redir_valid", redirect_valid, 1'b0);

        // ecall and mret both set: ecall sequence wins (mstatus is 0x1888 here)
        cyc();
        in_valid = 1'b1; in_ecall = 1'b1; in_mret = 1'b1; in_pc = 32'h0000_0200;
        exp_q.push_back(32'h8000_0100);
        cyc(); clear_in(); #1;
        chk("both1_wen", w_csr_en, 1'b1);
        chk("both1_addr", csr_addr, 12'h341);
        chk("both1_wdata", w_csr_data, 32'h0000_0200);
        cyc();
        cyc();
        cyc(); #1;
        chk("both4_wdata", w_csr_data, 32'h0000_1880);
        cyc();
        cyc();
        redirect_ready = 1'b1;
        #1 chk("both6_redir_valid", redirect_valid, 1'b1);
        cyc();
        redirect_ready = 1'b0;

        // reset while reading mstatus on the ecall path
        exu_write(12'h342, 32'h0);
        in_valid = 1'b1; in_ecall = 1'b1; in_pc = 32'h0000_0300;
        cyc(); clear_in();
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("rs_in_st_rd_ren", r_csr_en, 1'b1);
        chk("rs_in_st_rd_addr", csr_addr, 12'h300);
        cyc();
        rst = 1'b0;
        #1;
        chk("rs_busy", busy, 1'b0);
        chk("rs_redir_valid", redirect_valid, 1'b0);
        chk("rs_in_ready", in_ready, 1'b1);
        chk("rs_mepc", csr_mem[12'h341], 32'h0000_0300);
        chk("rs_mcause", csr_mem[12'h342], 32'd11);
        chk("rs_mstatus", csr_mem[12'h300], 32'h0000_1880);

        repeat (3) cyc();
        chk("sb_leftover", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
